// File: rtl/if_stage.sv
// MIPS instruction fetch stage with IF/ID register and req/ack imem port.
// Define IF_ADDR_EXC_EN to report misaligned redirect targets on if_id_adel.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
`ifdef IF_ADDR_EXC_EN
    output logic        if_id_adel,
`endif
    output logic        if_busy
);

    typedef enum logic [1:0] {
        S_REQ,
        S_BUF,
        S_DROP,
        S_ADEL
    } state_t;

    state_t      r_state;
    state_t      w_nxt;
    state_t      w_tgt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_hold;
    logic [31:0] r_buf_inst;
    logic [31:0] r_buf_pc;
    logic        r_req;
    logic        r_valid;
    logic [31:0] r_inst;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_pc4;
    logic        w_ack;
    logic        w_outst;
    logic        w_bub;
    logic        w_ld;
    logic        w_buf_ld;
    logic        w_hold_ld;
    logic [31:0] w_ld_inst;
    logic [31:0] w_ld_pc;
    logic [31:0] w_rpc;

    // An ack is only meaningful while our request is actually on the bus.
    assign w_ack   = imem_ack & r_req;
    assign w_outst = r_req & ~imem_ack;

`ifdef IF_ADDR_EXC_EN
    logic r_pend;
    logic w_pend_nxt;
    logic w_ld_adel;
    logic r_adel;

    assign w_rpc = redirect_pc;
    assign w_tgt = (redirect_pc[1:0] != 2'b00) ? S_ADEL : S_REQ;
`else
    assign w_rpc = {redirect_pc[31:2], 2'b00};
    assign w_tgt = S_REQ;
`endif

    always_comb begin
        w_nxt     = r_state;
        w_pc_nxt  = r_pc;
        w_bub     = 1'b0;
        w_ld      = 1'b0;
        w_buf_ld  = 1'b0;
        w_hold_ld = 1'b0;
        w_ld_inst = 32'h0;
        w_ld_pc   = 32'h0;
`ifdef IF_ADDR_EXC_EN
        w_ld_adel  = 1'b0;
        w_pend_nxt = r_pend;
`endif
        if (redirect_valid) begin
            // A fetch still in flight must complete at its old address.
            w_pc_nxt  = w_rpc;
            w_bub     = 1'b1;
            w_nxt     = w_outst ? S_DROP : w_tgt;
            w_hold_ld = (r_state == S_REQ);
`ifdef IF_ADDR_EXC_EN
            w_pend_nxt = (w_tgt == S_ADEL);
`endif
        end else begin
            unique case (r_state)
                S_REQ: begin
                    if (w_ack) begin
                        w_pc_nxt = r_pc + 32'd4;
                        if (id_stall) begin
                            w_buf_ld = 1'b1;
                            w_nxt    = S_BUF;
                        end else begin
                            w_ld      = 1'b1;
                            w_ld_inst = imem_rdata;
                            w_ld_pc   = r_pc;
                        end
                    end else if (!id_stall) begin
                        w_bub = 1'b1;
                    end
                end
                S_BUF: begin
                    if (!id_stall) begin
                        w_ld      = 1'b1;
                        w_ld_inst = r_buf_inst;
                        w_ld_pc   = r_buf_pc;
                        w_nxt     = S_REQ;
                    end
                end
                S_DROP: begin
                    w_bub = ~id_stall;
                    if (w_ack) begin
`ifdef IF_ADDR_EXC_EN
                        w_nxt = r_pend ? S_ADEL : S_REQ;
`else
                        w_nxt = S_REQ;
`endif
                    end
                end
                S_ADEL: begin
                    if (!id_stall) begin
`ifdef IF_ADDR_EXC_EN
                        if (r_pend) begin
                            w_ld       = 1'b1;
                            w_ld_pc    = r_pc;
                            w_ld_adel  = 1'b1;
                            w_pend_nxt = 1'b0;
                        end else begin
                            w_bub = 1'b1;
                        end
`else
                        w_bub = 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_req      <= 1'b0;
            r_hold     <= 32'h0;
            r_buf_inst <= 32'h0;
            r_buf_pc   <= 32'h0;
            r_valid    <= 1'b0;
            r_inst     <= 32'h0;
            r_id_pc    <= 32'h0;
            r_id_pc4   <= 32'h0;
        end else begin
            r_state <= w_nxt;
            r_pc    <= w_pc_nxt;
            r_req   <= (w_nxt == S_REQ) || (w_nxt == S_DROP);
            if (w_hold_ld) begin
                r_hold <= r_pc;
            end
            if (w_buf_ld) begin
                r_buf_inst <= imem_rdata;
                r_buf_pc   <= r_pc;
            end
            if (w_bub) begin
                r_valid <= 1'b0;
                r_inst  <= 32'h0;
            end else if (w_ld) begin
                r_valid  <= 1'b1;
                r_inst   <= w_ld_inst;
                r_id_pc  <= w_ld_pc;
                r_id_pc4 <= w_ld_pc + 32'd4;
            end
        end
    end

`ifdef IF_ADDR_EXC_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= 1'b0;
            r_adel <= 1'b0;
        end else begin
            r_pend <= w_pend_nxt;
            if (w_bub) begin
                r_adel <= 1'b0;
            end else if (w_ld) begin
                r_adel <= w_ld_adel;
            end
        end
    end

    assign if_id_adel = r_adel;
`endif

    assign imem_req    = r_req;
    assign imem_addr   = (r_state == S_DROP) ? r_hold : r_pc;
    assign if_busy     = r_req;
    assign if_id_valid = r_valid;
    assign if_id_inst  = r_inst;
    assign if_id_pc    = r_id_pc;
    assign if_id_pc4   = r_id_pc4;

endmodule

// File: tb/tb_if_stage.sv
// Randomised scoreboard bench for if_stage: program-order fetch model
// with redirect epochs, stalls, resets and variable memory latency.
module tb_if_stage;

    localparam logic [31:0] RPC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic        if_busy;
`ifdef IF_ADDR_EXC_EN
    logic        if_id_adel;
`endif

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(RPC)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .id_stall      (id_stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .if_id_valid   (if_id_valid),
        .if_id_inst    (if_id_inst),
        .if_id_pc      (if_id_pc),
        .if_id_pc4     (if_id_pc4),
`ifdef IF_ADDR_EXC_EN
        .if_id_adel    (if_id_adel),
`endif
        .if_busy       (if_busy)
    );

    int          errors = 0;
    int          checks = 0;
    exp_t        q[$];
    logic [31:0] model_pc;
    int          epoch = 0;
    int          req_ep = 0;
    int          lat = 0;
    bit          active = 0;
    int          min_lat = 0;
    int          max_lat = 0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        if (a == 32'h4) return 32'h0109_4820;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    // One clock of stimulus: memory responder plus the fetch-order model.
    task automatic cycle(input bit st, input bit red,
                         input logic [31:0] tgt, input bit ack_en,
                         input bit rs);
        bit          ack;
        logic [31:0] rd;
        exp_t        e;
        ack = 1'b0;
        rd  = $urandom;
        if (imem_req === 1'b1) begin
            if (!active) begin
                active = 1'b1;
                lat    = $urandom_range(min_lat, max_lat);
                req_ep = epoch;
            end
            if (ack_en && lat == 0) begin
                ack = 1'b1;
                rd  = mem(imem_addr);
            end else if (lat != 0) begin
                lat--;
            end
        end else begin
            active = 1'b0;
            ack    = ack_en && ($urandom_range(0, 7) == 0);
            rd     = 32'hDEAD_BEEF;
        end
        if (rs) begin
            q.delete();
            model_pc = RPC;
            epoch++;
            active = 1'b0;
        end else if (red) begin
            q.delete();
            epoch++;
`ifdef IF_ADDR_EXC_EN
            model_pc = tgt;
            if (tgt[1:0] != 2'b00) begin
                e.pc   = tgt;
                e.inst = 32'h0;
                e.adel = 1'b1;
                q.push_back(e);
            end
`else
            model_pc = {tgt[31:2], 2'b00};
`endif
        end else if (ack && imem_req === 1'b1 && req_ep == epoch) begin
            chk("fetch_addr", imem_addr, model_pc);
            e.pc   = model_pc;
            e.inst = rd;
            e.adel = 1'b0;
            q.push_back(e);
            model_pc = model_pc + 32'd4;
        end
        if (ack) active = 1'b0;
        rst            = rs;
        id_stall       = st;
        redirect_valid = red;
        redirect_pc    = tgt;
        imem_ack       = ack;
        imem_rdata     = rd;
        @(negedge clk);
    endtask

    // Monitor: checks what each rising edge did to the IF/ID register.
    logic        prev_rst = 1'b1;
    logic        p_req = 1'b0;
    logic [31:0] p_addr = 32'h0;
    logic        p_valid = 1'b0;
    logic [31:0] p_inst = 32'h0;
    logic [31:0] p_pc = 32'h0;
    logic [31:0] p_pc4 = 32'h0;

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                chk("rst_valid", {31'b0, if_id_valid}, 32'h0);
                chk("rst_inst", if_id_inst, 32'h0);
                chk("rst_pc", if_id_pc, 32'h0);
                chk("rst_pc4", if_id_pc4, 32'h0);
                chk("rst_req", {31'b0, imem_req}, 32'h0);
`ifdef IF_ADDR_EXC_EN
                chk("rst_adel", {31'b0, if_id_adel}, 32'h0);
`endif
            end else begin
                chk("busy", {31'b0, if_busy}, {31'b0, imem_req});
                if (prev_rst && !redirect_valid)
                    chk("req_rise", {31'b0, imem_req}, 32'h1);
                if (p_req && !imem_ack) begin
                    chk("req_hold", {31'b0, imem_req}, 32'h1);
                    chk("addr_hold", imem_addr, p_addr);
                end
                if (redirect_valid) begin
                    chk("flush_valid", {31'b0, if_id_valid}, 32'h0);
                    chk("flush_inst", if_id_inst, 32'h0);
                end else if (id_stall) begin
                    chk("stall_valid", {31'b0, if_id_valid},
                        {31'b0, p_valid});
                    chk("stall_inst", if_id_inst, p_inst);
                    chk("stall_pc", if_id_pc, p_pc);
                    chk("stall_pc4", if_id_pc4, p_pc4);
                end else if (if_id_valid) begin
                    if (q.size() == 0) begin
                        chk("spurious_pc", if_id_pc, 32'hFFFF_FFFF);
                    end else begin
                        e = q.pop_front();
                        chk("id_pc", if_id_pc, e.pc);
                        chk("id_inst", if_id_inst, e.inst);
                        chk("id_pc4", if_id_pc4, e.pc + 32'd4);
`ifdef IF_ADDR_EXC_EN
                        chk("id_adel", {31'b0, if_id_adel},
                            {31'b0, e.adel});
`endif
                    end
                end else begin
                    chk("bubble_inst", if_id_inst, 32'h0);
                end
            end
            prev_rst = rst;
            p_req    = imem_req;
            p_addr   = imem_addr;
            p_valid  = if_id_valid;
            p_inst   = if_id_inst;
            p_pc     = if_id_pc;
            p_pc4    = if_id_pc4;
        end
    end

    function automatic logic [31:0] rnd_tgt();
        logic [31:0] t;
        if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFF0;
        else t = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
        if ($urandom_range(0, 5) == 0)
            t[1:0] = 2'($urandom_range(1, 3));
        return t;
    endfunction

    initial begin
        rst            = 1'b1;
        id_stall       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        model_pc       = RPC;
        repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        min_lat = 0;
        max_lat = 0;
        repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        min_lat = 2;
        max_lat = 2;
        repeat (12) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        repeat (4) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 32'h100, 1'b1, 1'b0);
        repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        min_lat = 0;
        max_lat = 3;
        for (int i = 0; i < 3000; i++) begin
            bit st;
            bit red;
            bit rs;
            st  = ($urandom_range(0, 3) == 0);
            red = ($urandom_range(0, 12) == 0);
            rs  = ($urandom_range(0, 600) == 0);
            cycle(st, red, rnd_tgt(), 1'b1, rs);
        end
        repeat (8) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        chk("drain_left", q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the pipelined MIPS CPU.
- Holds the PC and issues fetches over a req/ack instruction-memory handshake with variable latency.
- Presents the fetched instruction, its PC and PC+4 to the ID-stage decoder.
- Obeys hazard stalls from ID and PC redirects (branch, j/jal, jr/jalr, exception, eret) resolved downstream.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address; word aligned
- imem_ack  in  1  fetch done; imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction
- id_stall  in  1  hazard unit: hold IF/ID
- redirect_valid  in  1  take new PC, flush IF/ID
- redirect_pc  in  32  target PC
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_inst  out  32  instruction to decoder; 32'b0 (nop) when invalid
- if_id_pc  out  32  PC of if_id_inst
- if_id_pc4  out  32  if_id_pc + 4, used by jal/jalr link
- if_busy  out  1  fetch outstanding (state REQ or DROP)

Behaviour:
- Reset values: pc=RESET_PC, state=REQ, skid buffer empty, if_id_valid=0, if_id_inst=0, if_id_pc=0, if_id_pc4=0.
  - imem_req is registered and is 0 during the reset cycle; it rises in the first cycle after rst deasserts.
- Bus rule: once imem_req=1, imem_req and imem_addr stay stable until imem_ack. An ack in the same cycle as req (zero-wait memory) is legal. imem_ack while imem_req=0 is ignored.
- imem_addr = pc in REQ; it is the held address in DROP.
- Arithmetic: 32-bit; pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- IF/ID load condition: id_stall=0. When id_stall=1, the IF/ID outputs hold, whether or not if_id_valid is set.
- States:
  - REQ: imem_req=1. On ack with no redirect:
    - If id_stall=0: IF/ID <= {1, rdata, pc, pc+4}; pc <= pc+4; stay in REQ (back-to-back, 1 instruction/cycle with a zero-wait memory).
    - If id_stall=1: rdata and pc go into the skid buffer; pc <= pc+4; go to BUF.
    - If no ack and id_stall=0: IF/ID <= bubble (valid=0, inst=0).
  - BUF: imem_req=0. When id_stall=0: IF/ID <= buffer contents, go to REQ. Fetch resumes the next cycle, so there is 1 bubble-free handoff.
  - DROP: imem_req=1 at the old address. On ack: discard rdata, go to REQ with the already-updated pc.
- Redirect is highest priority after rst and overrides id_stall:
  - pc <= redirect_pc; IF/ID <= bubble.
  - REQ with no ack this cycle goes to DROP.
  - REQ with ack this cycle discards the data and stays in REQ.
  - BUF discards the buffer and goes to REQ.
  - DROP stays in DROP; pc is overwritten by the latest redirect.
- A second redirect while in DROP: the last one wins.
- rst mid-request: everything returns to reset values immediately. Any late ack for the abandoned request arrives while imem_req=0 and is ignored.
- Fetched instruction latency: ack cycle -> visible at if_id_inst on the next rising edge.

Optional Feature:
- Macro IF_ADDR_EXC_EN.
- Defined:
  - Adds output if_id_adel (1 bit, reset 0).
  - A redirect_pc with [1:0]!=0 issues no memory request. The next IF/ID load is {valid=1, inst=0, pc=redirect_pc, pc4=redirect_pc+4, adel=1}.
  - The stage then idles, with imem_req=0, until the next redirect.
  - adel clears on any other IF/ID load.
- Undefined:
  - Port absent; redirect_pc[1:0] is ignored and treated as 0.

Test Plan:
- Reset RESET_PC=0, zero-wait memory returning 0x20080005 then 0x01094820 -> imem_req rises the cycle after rst drops. IF/ID shows {1, 0x20080005, 0x0, 0x4}, then {1, 0x01094820, 0x4, 0x8} on consecutive cycles.
- 3-cycle memory latency -> if_busy=1 for 3 cycles, bubbles (inst=0, valid=0) in IF/ID meanwhile, and imem_addr held stable.
- id_stall=1 for 4 cycles coincident with an ack of 0x8C020010 at pc=0x8 -> IF/ID unchanged, state BUF, imem_req=0. The cycle after stall drops, IF/ID={0x8C020010, 0x8, 0xC}, then a fetch at 0xC.
- redirect_valid with redirect_pc=0x100 during an outstanding fetch at 0x10, ack 2 cycles later -> data for 0x10 never appears in IF/ID, and the next request address is 0x100.
- redirect together with id_stall=1 and ack in the same cycle -> IF/ID becomes a bubble, the ack data is dropped, and the next fetch is at the target.
- rst asserted mid-request, then a late ack -> ack is ignored, and the first fetch after reset is at RESET_PC. With IF_ADDR_EXC_EN, redirect_pc=0x102 -> IF/ID pc=0x102, if_id_adel=1, no imem_req.
